// File: rtl/spram_byte_dma.sv
// Byte DMA between a valid/ready stream pair and a single-port RAM with fixed read latency.
// Define SPRAM_DMA_WRAP_EN to let the pointer wrap at the top of the 128 KiB space.
module spram_byte_dma #(
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [16:0] cmd_addr,
    input  logic [16:0] cmd_len,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [16:0] mem_addr,
    output logic        mem_wr_en,
    output logic [7:0]  mem_wr_data,
    input  logic [7:0]  mem_rd_data
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [16:0]           ptr_q, ptr_d;
    logic [17:0]           rem_q, rem_d;
    logic [16:0]           addr_q, addr_d;
    logic                  err_q, err_d;
    logic [RD_LATENCY-1:0] sr_q, sr_d;
    logic [7:0]            fifo_q [FIFO_DEPTH];
    logic [7:0]            fifo_d [FIFO_DEPTH];
    logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic        wr_fire, issue, push, pop, range_bad;
    logic [15:0] in_flight, occ;
`ifndef SPRAM_DMA_WRAP_EN
    logic [17:0] end_addr;
`endif

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            in_flight = in_flight + 16'(sr_q[i]);
        end
        push    = sr_q[RD_LATENCY-1];
        pop     = (cnt_q != '0) && m_ready;
        // A same-cycle pop frees a slot, which keeps reads at one per cycle.
        occ     = in_flight + 16'(cnt_q) - 16'(pop);
        issue   = (state_q == S_READ) && (rem_q != '0)
                  && (occ < 16'(FIFO_DEPTH));
        wr_fire = (state_q == S_WRITE) && s_valid;
`ifdef SPRAM_DMA_WRAP_EN
        range_bad = 1'b0;
`else
        end_addr  = {1'b0, cmd_addr} + {1'b0, cmd_len};
        range_bad = end_addr[17];
`endif

        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        err_d   = 1'b0;
        sr_d    = sr_q << 1;
        sr_d[0] = issue;
        fifo_d  = fifo_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        cnt_d   = cnt_q + CW'(push) - CW'(pop);

        if (push) begin
            fifo_d[wp_q] = mem_rd_data;
            wp_d = (wp_q == PW'(FIFO_DEPTH - 1)) ? '0 : wp_q + PW'(1);
        end
        if (pop) begin
            rp_d = (rp_q == PW'(FIFO_DEPTH - 1)) ? '0 : rp_q + PW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (range_bad) begin
                        err_d = 1'b1;
                    end else begin
                        ptr_d   = cmd_addr;
                        rem_d   = {1'b0, cmd_len} + 18'd1;
                        state_d = cmd_write ? S_WRITE : S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (wr_fire) begin
                    ptr_d = ptr_q + 17'd1;
                    rem_d = rem_q - 18'd1;
                    if (rem_q == 18'd1) state_d = S_DONE;
                end
            end
            S_READ: begin
                if (issue) begin
                    ptr_d = ptr_q + 17'd1;
                    rem_d = rem_q - 18'd1;
                end
                if ((rem_q == '0) && (in_flight == '0)
                    && ((cnt_q == '0) || ((cnt_q == CW'(1)) && pop))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        addr_d = (wr_fire || issue) ? ptr_q : addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            sr_q    <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            sr_q    <= sr_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            fifo_q  <= fifo_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;
    assign s_ready     = (state_q == S_WRITE);
    assign mem_wr_en   = wr_fire;
    assign mem_wr_data = wr_fire ? s_data : '0;
    assign mem_addr    = addr_d;
    assign m_valid     = (cnt_q != '0);
    assign m_data      = fifo_q[rp_q];

endmodule

// File: tb/tb_spram_byte_dma.sv
// Directed bench for spram_byte_dma: transaction-level model of expected
// writes and stream bytes, checked every cycle, plus hand-computed cases.
module tb_spram_byte_dma;
    localparam int L = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [16:0] cmd_addr, cmd_len;
    logic        s_valid, s_ready;
    logic [7:0]  s_data;
    logic        m_valid, m_ready;
    logic [7:0]  m_data;
    logic        busy, done, err;
    logic [16:0] mem_addr;
    logic        mem_wr_en;
    logic [7:0]  mem_wr_data, mem_rd_data;

    spram_byte_dma #(.RD_LATENCY(L), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory with an L-cycle registered read path
    logic [7:0] mem_m [131072];
    logic [7:0] p0, p1;
    assign mem_rd_data = p1;
    always @(posedge clk) begin
        if (mem_wr_en) mem_m[mem_addr] <= mem_wr_data;
        p0 <= mem_m[mem_addr];
        p1 <= p0;
    end

    logic [24:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    int checks = 0, errors = 0;
    int done_cnt = 0, err_cnt = 0, done_cyc = -1, err_cyc = -1;
    int last_wr_cyc = -1, first_mv_cyc = -1;
    int first_pop = -1, last_pop = -1, pop_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic [24:0] e;
        if (rst_n) begin
            chk("busy_vs_ready", {31'd0, busy}, {31'd0, !cmd_ready});
            if (s_ready) chk("s_ready_busy", {31'd0, busy}, 32'd1);
            if (mem_wr_en) begin
                last_wr_cyc = cyc;
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                             mem_addr, mem_wr_data);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", {15'd0, mem_addr}, {15'd0, e[24:8]});
                    chk("wr_data", {24'd0, mem_wr_data}, {24'd0, e[7:0]});
                end
            end
            if (m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
            if (m_valid && m_ready) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                pop_cnt++;
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", m_data);
                end else begin
                    chk("rd_data", {24'd0, m_data}, {24'd0, exp_rd.pop_front()});
                end
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err)  begin err_cnt++;  err_cyc = cyc;  end
        end
    end

    task automatic send_cmd(input logic w, input logic [16:0] a,
                            input logic [16:0] l, output int acc);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        acc = -1;
        for (int k = 0; k < 50 && acc < 0; k++) begin
            @(negedge clk);
            if (cmd_ready) acc = cyc;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (acc < 0) begin
            checks++; errors++;
            $display("FAIL cmd_accept_timeout: got no cmd_ready expected accept");
        end
    endtask

    task automatic stream(input logic [7:0] b[$], input bit gapped);
        foreach (b[i]) begin
            bit hs = 0;
            if (gapped && (i % 2 == 1)) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_valid = 1'b1; s_data = b[i];
            for (int k = 0; k < 50 && !hs; k++) begin
                @(negedge clk);
                if (s_ready) hs = 1;
                @(posedge clk); #1;
            end
            if (!hs) begin
                checks++; errors++;
                $display("FAIL s_handshake_timeout: got no s_ready expected handshake");
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, input int maxc, input bit rd_mode,
                             input bit toggle);
        for (int k = 0; k < maxc && done_cnt == start; k++) begin
            if (rd_mode) m_ready = toggle ? ((k / 3) % 2 == 0) : 1'b1;
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("single_done", done_cnt, start + 1);
    endtask

    int acc, d0, e0;
    logic [7:0] bq[$];

    initial begin
        rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        s_valid = 0; s_data = '0; m_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_mem_addr", {15'd0, mem_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, mem_wr_data}, 32'd0);
        chk("rst_m_data", {24'd0, m_data}, 32'd0);
        @(posedge clk); #1;

        // Gapped 4-byte write at 0x10
        bq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        foreach (bq[i]) exp_wr.push_back({17'h10 + 17'(i), bq[i]});
        d0 = done_cnt;
        send_cmd(1'b1, 17'h10, 17'd3, acc);
        stream(bq, 1'b1);
        wait_done(d0, 50, 1'b0, 1'b0);
        chk("wr_done_latency", done_cyc, last_wr_cyc + 1);
        chk("wr_all_seen", exp_wr.size(), 0);
        chk("mem_0x10", {24'd0, mem_m[17'h10]}, 32'hA1);
        chk("mem_0x13", {24'd0, mem_m[17'h13]}, 32'hA4);
        chk("hold_addr_idle", {15'd0, mem_addr}, 32'h13);

        // Read back with m_ready high
        exp_rd = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        first_mv_cyc = -1; first_pop = -1; m_ready = 1;
        d0 = done_cnt;
        send_cmd(1'b0, 17'h10, 17'd3, acc);
        wait_done(d0, 50, 1'b1, 1'b0);
        chk("rd_first_valid", first_mv_cyc, acc + L + 2);
        chk("rd_back_to_back", last_pop - first_pop, 3);
        chk("rd_all_seen", exp_rd.size(), 0);

        // 16 bytes at 0x40, then read back with m_ready toggling
        bq = {};
        for (int i = 0; i < 16; i++) bq.push_back(8'(i * 13 + 5));
        foreach (bq[i]) exp_wr.push_back({17'h40 + 17'(i), bq[i]});
        d0 = done_cnt;
        send_cmd(1'b1, 17'h40, 17'd15, acc);
        stream(bq, 1'b0);
        wait_done(d0, 50, 1'b0, 1'b0);
        chk("mem_0x45", {24'd0, mem_m[17'h45]}, 32'h46);
        foreach (bq[i]) exp_rd.push_back(bq[i]);
        e0 = pop_cnt; d0 = done_cnt;
        send_cmd(1'b0, 17'h40, 17'd15, acc);
        wait_done(d0, 200, 1'b1, 1'b1);
        chk("toggle_pop_count", pop_cnt - e0, 16);
        chk("toggle_all_seen", exp_rd.size(), 0);
        m_ready = 0;

        // Command crossing the top of memory
        s_valid = 1; s_data = 8'h5A;
        e0 = err_cnt; d0 = done_cnt;
`ifdef SPRAM_DMA_WRAP_EN
        exp_wr.push_back({17'h1FFFE, 8'h5A});
        exp_wr.push_back({17'h1FFFF, 8'h5A});
        exp_wr.push_back({17'h00000, 8'h5A});
        send_cmd(1'b1, 17'h1FFFE, 17'd2, acc);
        wait_done(d0, 50, 1'b0, 1'b0);
        s_valid = 0;
        chk("wrap_all_seen", exp_wr.size(), 0);
        chk("wrap_no_err", err_cnt, e0);
`else
        send_cmd(1'b1, 17'h1FFFE, 17'd2, acc);
        repeat (4) @(posedge clk);
        #1 s_valid = 0;
        chk("err_cycle", err_cyc, acc + 1);
        chk("err_single", err_cnt, e0 + 1);
        chk("err_no_done", done_cnt, d0);
        chk("err_cmd_ready", {31'd0, cmd_ready}, 32'd1);
`endif

        // Write ending exactly at the last byte address
        bq = '{8'h11, 8'h22, 8'h33, 8'h44};
        foreach (bq[i]) exp_wr.push_back({17'h1FFFC + 17'(i), bq[i]});
        d0 = done_cnt;
        send_cmd(1'b1, 17'h1FFFC, 17'd3, acc);
        stream(bq, 1'b0);
        wait_done(d0, 50, 1'b0, 1'b0);
        chk("top_final_addr", {15'd0, mem_addr}, 32'h1FFFF);
        chk("top_mem", {24'd0, mem_m[17'h1FFFF]}, 32'h44);

        // Reset while the FIFO holds 3 bytes
        m_ready = 0;
        send_cmd(1'b0, 17'h40, 17'd7, acc);
        for (int k = 0; k < 20 && cyc < acc + L + 4; k++) @(negedge clk);
        chk("pre_rst_m_valid", {31'd0, m_valid}, 32'd1);
        #1 rst_n = 0;
        #1;
        chk("rst_mid_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_addr", {15'd0, mem_addr}, 32'd0);
        @(posedge clk); #1 rst_n = 1;
        exp_rd = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        first_mv_cyc = -1; first_pop = -1; m_ready = 1;
        d0 = done_cnt;
        send_cmd(1'b0, 17'h10, 17'd3, acc);
        wait_done(d0, 50, 1'b1, 1'b0);
        chk("post_rst_first_valid", first_mv_cyc, acc + L + 2);
        chk("post_rst_all_seen", exp_rd.size(), 0);

        // Full-length command: counter must not read as complete early
        bq = {};
        for (int i = 0; i < 300; i++) bq.push_back(8'(i) ^ 8'h3C);
        foreach (bq[i]) exp_wr.push_back({17'(i), bq[i]});
        d0 = done_cnt;
        send_cmd(1'b1, 17'h0, 17'h1FFFF, acc);
        stream(bq, 1'b0);
        @(negedge clk);
        chk("long_busy", {31'd0, busy}, 32'd1);
        chk("long_no_done", done_cnt, d0);
        chk("long_all_seen", exp_wr.size(), 0);
        #1 rst_n = 0;
        #1 chk("long_abort", {31'd0, busy}, 32'd0);
        @(posedge clk); #1 rst_n = 1;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
